rrq_wrr: RTL and testbench

- Parametrised weighted round-robin read-request arbiter. Successor to the fixed read-request queue scheduler.
- Watches the per-app data-queue empty flags and picks one app at a time. Issues a single-cycle read_queue strobe with app_id, then holds until read_done.
- Adds a per-app enable mask, per-app burst weights, a fixed-priority mode, and a read_done watchdog timeout.
- Sits between the per-app data queues and the shared read engine.

---
 rtl/rrq_wrr.sv | 161 ++++++++++++++++
 tb/tb_rrq_wrr.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rrq_wrr.sv
// Weighted round-robin read-request arbiter: picks one non-empty, enabled app queue,
// strobes read_queue with app_id, then waits for read_done or a watchdog expiry.
module rrq_wrr #(
  parameter int TOTAL_APPS     = 8,
  parameter int APP_ID_WIDTH   = 3,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int MODE           = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [TOTAL_APPS-1:0]                app_enable,
  input  logic [TOTAL_APPS*WEIGHT_WIDTH-1:0]   app_weight,
  input  logic [TOTAL_APPS-1:0]                data_queue_empty,
  input  logic                                 read_done,
  output logic                                 read_queue,
  output logic [APP_ID_WIDTH-1:0]              app_id,
  output logic                                 busy,
  output logic                                 timeout_err
);

  // A zero timeout still needs a legal one-bit counter even though it never fires.
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [APP_ID_WIDTH-1:0] LAST_APP = APP_ID_WIDTH'(TOTAL_APPS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t                    state_q, state_d;
  logic [APP_ID_WIDTH-1:0]   holder_q, holder_d;
  logic [WEIGHT_WIDTH-1:0]   credit_q, credit_d;
  logic [CNT_W-1:0]          wd_q, wd_d;
  logic [APP_ID_WIDTH-1:0]   app_id_q, app_id_d;
  logic                      read_queue_q, read_queue_d;
  logic                      busy_q, busy_d;
  logic                      timeout_err_q, timeout_err_d;

  logic [TOTAL_APPS-1:0]     req;
  logic [WEIGHT_WIDTH-1:0]   weight [TOTAL_APPS];
  logic [APP_ID_WIDTH-1:0]   sel;
  logic [APP_ID_WIDTH-1:0]   cand;
  logic                      found;
  logic [APP_ID_WIDTH-1:0]   sel_holder;
  logic [WEIGHT_WIDTH-1:0]   sel_credit;

  assign req = ~data_queue_empty & app_enable;

  always_comb begin
    for (int i = 0; i < TOTAL_APPS; i++) begin
      weight[i] = app_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  // Explicit wrap keeps the rotation correct for non-power-of-two app counts.
  function automatic logic [APP_ID_WIDTH-1:0] next_idx(input logic [APP_ID_WIDTH-1:0] i);
    return (i == LAST_APP) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    sel        = '0;
    sel_holder = holder_q;
    sel_credit = credit_q;
    found      = 1'b0;
    cand       = holder_q;
    if (MODE == 1) begin
      for (int i = TOTAL_APPS - 1; i >= 0; i--) begin
        if (req[i]) sel = APP_ID_WIDTH'(i);
      end
    end else if (req[holder_q] && (credit_q != '0)) begin
      sel        = holder_q;
      sel_credit = credit_q - 1'b1;
    end else begin
      // The holder is the final candidate, so a lone requester keeps winning.
      for (int k = 0; k < TOTAL_APPS; k++) begin
        cand = next_idx(cand);
        if (!found && req[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
      sel_holder = sel;
      sel_credit = (weight[sel] == '0) ? '0 : weight[sel] - 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    holder_d      = holder_q;
    credit_d      = credit_q;
    wd_d          = wd_q;
    app_id_d      = app_id_q;
    read_queue_d  = 1'b0;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d      = ST_WAIT;
          app_id_d     = sel;
          read_queue_d = 1'b1;
          busy_d       = 1'b1;
          wd_d         = '0;
          if (MODE == 0) begin
            holder_d = sel_holder;
            credit_d = sel_credit;
          end
        end
      end
      ST_WAIT: begin
        // A completion on the expiry cycle takes precedence over the watchdog.
        if (read_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
          state_d       = ST_IDLE;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
          credit_d      = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      holder_q      <= LAST_APP;
      credit_q      <= '0;
      wd_q          <= '0;
      app_id_q      <= '0;
      read_queue_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      holder_q      <= holder_d;
      credit_q      <= credit_d;
      wd_q          <= wd_d;
      app_id_q      <= app_id_d;
      read_queue_q  <= read_queue_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign read_queue  = read_queue_q;
  assign app_id      = app_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rrq_wrr.sv
// Directed bench for rrq_wrr: one weighted round-robin instance and one fixed-priority
// instance share all inputs; each phase resets both and checks only the relevant one.
module tb_rrq_wrr;

  logic        clk;
  logic        rstn;
  logic [7:0]  appEnable;
  logic [31:0] appWeight;
  logic [7:0]  dataQueueEmpty;
  logic        readDone;

  logic        rqRr, busyRr, toRr;
  logic [2:0]  idRr;
  logic        rqFp, busyFp, toFp;
  logic [2:0]  idFp;

  int checks = 0;
  int errors = 0;

  rrq_wrr #(
    .TOTAL_APPS(8), .APP_ID_WIDTH(3), .WEIGHT_WIDTH(4), .MODE(0), .TIMEOUT_CYCLES(16)
  ) dutRr (
    .clk(clk), .rstn(rstn), .app_enable(appEnable), .app_weight(appWeight),
    .data_queue_empty(dataQueueEmpty), .read_done(readDone),
    .read_queue(rqRr), .app_id(idRr), .busy(busyRr), .timeout_err(toRr)
  );

  rrq_wrr #(
    .TOTAL_APPS(8), .APP_ID_WIDTH(3), .WEIGHT_WIDTH(4), .MODE(1), .TIMEOUT_CYCLES(16)
  ) dutFp (
    .clk(clk), .rstn(rstn), .app_enable(appEnable), .app_weight(appWeight),
    .data_queue_empty(dataQueueEmpty), .read_done(readDone),
    .read_queue(rqFp), .app_id(idFp), .busy(busyFp), .timeout_err(toFp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    checks++;
    assert (obs === expVal) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expVal);
    end
  endtask

  task automatic applyReset();
    readDone = 1'b0;
    rstn     = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // Steps until the selected instance strobes read_queue; leaves time in the strobe cycle.
  task automatic waitGrant(input bit fp, input string tag, output logic [2:0] id);
    bit seen = 1'b0;
    id = '0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if ((fp ? rqFp : rqRr) === 1'b1) begin
        seen = 1'b1;
        id   = fp ? idFp : idRr;
      end
    end
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  // One full transaction: grant, read_done three cycles later, busy low the cycle after.
  task automatic runGrant(input bit fp, input logic [2:0] expId, input string tag);
    logic [2:0] id;
    waitGrant(fp, tag, id);
    checkOutput({tag, "_id"}, 32'(id), 32'(expId));
    step();
    step();
    step();
    readDone = 1'b1;
    step();
    readDone = 1'b0;
    checkOutput({tag, "_busy_clr"}, 32'(fp ? busyFp : busyRr), 32'd0);
  endtask

  initial begin
    logic [2:0] gid;
    bit         anySeen;

    appEnable      = 8'hFF;
    appWeight      = {8{4'h1}};
    dataQueueEmpty = 8'hFF;
    readDone       = 1'b0;
    rstn           = 1'b0;
    #1;
    checkOutput("rst_rq",   32'(rqRr),   32'd0);
    checkOutput("rst_id",   32'(idRr),   32'd0);
    checkOutput("rst_busy", 32'(busyRr), 32'd0);
    checkOutput("rst_to",   32'(toRr),   32'd0);

    // Grant from reset with a single requester.
    applyReset();
    step();
    checkOutput("t1_idle_rq", 32'(rqRr), 32'd0);
    step();
    checkOutput("t1_idle_rq2", 32'(rqRr), 32'd0);
    dataQueueEmpty = 8'b1111_1011;
    step();
    checkOutput("t1_rq",   32'(rqRr),   32'd1);
    checkOutput("t1_id",   32'(idRr),   32'd2);
    checkOutput("t1_busy", 32'(busyRr), 32'd1);
    dataQueueEmpty = 8'hFF;
    step();
    checkOutput("t1_rq_pulse", 32'(rqRr),   32'd0);
    checkOutput("t1_busy_hold", 32'(busyRr), 32'd1);
    readDone = 1'b1;
    step();
    readDone = 1'b0;
    checkOutput("t1_busy_clr", 32'(busyRr), 32'd0);
    checkOutput("t1_id_hold",  32'(idRr),   32'd2);

    // Plain round robin between apps 1 and 5.
    applyReset();
    appWeight      = {8{4'h1}};
    dataQueueEmpty = 8'b1101_1101;
    runGrant(1'b0, 3'd1, "t2_g0");
    runGrant(1'b0, 3'd5, "t2_g1");
    runGrant(1'b0, 3'd1, "t2_g2");
    runGrant(1'b0, 3'd5, "t2_g3");
    runGrant(1'b0, 3'd1, "t2_g4");

    // Weighted: app 0 weight 3, app 3 weight 1.
    applyReset();
    appWeight      = 32'h0000_1003;
    dataQueueEmpty = 8'b1111_0110;
    runGrant(1'b0, 3'd0, "t3_g0");
    runGrant(1'b0, 3'd0, "t3_g1");
    runGrant(1'b0, 3'd0, "t3_g2");
    runGrant(1'b0, 3'd3, "t3_g3");
    runGrant(1'b0, 3'd0, "t3_g4");
    runGrant(1'b0, 3'd0, "t3_g5");
    runGrant(1'b0, 3'd0, "t3_g6");
    runGrant(1'b0, 3'd3, "t3_g7");

    // Weight 0 behaves as weight 1.
    applyReset();
    appWeight = 32'h0000_1000;
    runGrant(1'b0, 3'd0, "t3z_g0");
    runGrant(1'b0, 3'd3, "t3z_g1");
    runGrant(1'b0, 3'd0, "t3z_g2");
    runGrant(1'b0, 3'd3, "t3z_g3");

    // Fixed priority instance.
    applyReset();
    appWeight      = {8{4'h1}};
    dataQueueEmpty = 8'b1011_1011;
    runGrant(1'b1, 3'd2, "t4_g0");
    runGrant(1'b1, 3'd2, "t4_g1");
    runGrant(1'b1, 3'd2, "t4_g2");
    dataQueueEmpty = 8'b1011_1111;
    runGrant(1'b1, 3'd6, "t4_g3");
    appEnable = 8'hBF;
    anySeen   = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (rqFp === 1'b1) anySeen = 1'b1;
    end
    checkOutput("t4_no_grant", 32'(anySeen), 32'd0);
    appEnable = 8'hFF;

    // Watchdog expiry with read_done withheld.
    applyReset();
    appWeight      = 32'h0000_0040;
    dataQueueEmpty = 8'b1110_1101;
    waitGrant(1'b0, "t5_g0", gid);
    checkOutput("t5_g0_id", 32'(gid), 32'd1);
    anySeen = 1'b0;
    for (int n = 1; n < 16; n++) begin
      step();
      if (toRr !== 1'b0 || busyRr !== 1'b1) anySeen = 1'b1;
    end
    checkOutput("t5_early", 32'(anySeen), 32'd0);
    step();
    checkOutput("t5_to",      32'(toRr),   32'd1);
    checkOutput("t5_busy",    32'(busyRr), 32'd0);
    step();
    checkOutput("t5_to_pulse", 32'(toRr), 32'd0);
    checkOutput("t5_next_rq",  32'(rqRr), 32'd1);
    checkOutput("t5_next_id",  32'(idRr), 32'd4);

    // read_done on the expiry cycle suppresses the timeout.
    applyReset();
    waitGrant(1'b0, "t5b_g0", gid);
    checkOutput("t5b_g0_id", 32'(gid), 32'd1);
    for (int n = 1; n < 16; n++) step();
    readDone = 1'b1;
    step();
    readDone = 1'b0;
    checkOutput("t5b_no_to", 32'(toRr),   32'd0);
    checkOutput("t5b_busy",  32'(busyRr), 32'd0);
    step();
    checkOutput("t5b_no_to2",  32'(toRr), 32'd0);
    checkOutput("t5b_next_rq", 32'(rqRr), 32'd1);
    checkOutput("t5b_next_id", 32'(idRr), 32'd1);

    // Asynchronous reset in the middle of a wait.
    applyReset();
    appWeight      = {8{4'h1}};
    dataQueueEmpty = 8'b0111_0111;
    runGrant(1'b0, 3'd3, "t6_g0");
    waitGrant(1'b0, "t6_g1", gid);
    checkOutput("t6_g1_id", 32'(gid), 32'd7);
    step();
    checkOutput("t6_busy_pre", 32'(busyRr), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("t6_rst_busy", 32'(busyRr), 32'd0);
    checkOutput("t6_rst_id",   32'(idRr),   32'd0);
    checkOutput("t6_rst_rq",   32'(rqRr),   32'd0);
    checkOutput("t6_rst_to",   32'(toRr),   32'd0);
    step();
    rstn = 1'b1;
    waitGrant(1'b0, "t6_g2", gid);
    checkOutput("t6_g2_id",   32'(gid),    32'd3);
    checkOutput("t6_g2_busy", 32'(busyRr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
